regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_arbiter_pkg.sv | 16 +
 rtl/regfile_arbiter_rr_arb2.sv | 17 +
 rtl/regfile_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_regfile_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared defaults and state encoding for the two-port register-file arbiter.
package regfile_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_ADDR_DEPTH = 12;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_INIT = 1'b1
  } state_e;

  // Round-robin pointer values: which requester holds priority on a tie.
  localparam logic PTR_A = 1'b0;
  localparam logic PTR_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_rr_arb2.sv
// Two-way round-robin pick: one-hot grant from two requests and a priority pointer.
module rr_arb2
  import regfile_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == PTR_B) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a single-port register file and provides a
// whole-file zero-fill sequence.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_DEPTH = DEF_ADDR_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  init_start,
  output logic                  init_busy,
  output logic                  init_done,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_DEPTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_DEPTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_DEPTH-1:0] rf_address,
  output logic                  rf_en_write,
  output logic                  rf_en_read,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  input  logic [DATA_WIDTH-1:0] rf_data_out
);

  localparam int CNT_W = ADDR_DEPTH + 1;

  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic [ADDR_DEPTH-1:0] rf_address_q, rf_address_d;
  logic                  rf_en_write_q, rf_en_write_d;
  logic                  rf_en_read_q, rf_en_read_d;
  logic [DATA_WIDTH-1:0] rf_data_in_q, rf_data_in_d;
  logic                  rd_owner_q, rd_owner_d;
  logic                  rd_vld_p1_q, rd_vld_p1_d;
  logic                  rd_owner_p1_q, rd_owner_p1_d;
  logic                  a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  init_busy_q, init_busy_d;
  logic                  init_done_q, init_done_d;

  logic       init_go;
  logic       sel_we;
  logic [1:0] elig;
  logic [1:0] pick;

  // init_start takes precedence over any request in the same cycle.
  assign init_go = (state_q == ST_ARB) && init_start && !init_busy_q;
  // A requester already showing gnt this cycle is still holding the same request.
  assign elig    = {b_req & ~b_gnt_q, a_req & ~a_gnt_q}
                 & {2{(state_q == ST_ARB) && !init_go}};
  assign sel_we  = pick[0] ? a_we : b_we;

  rr_arb2 u_rr_arb2 (
    .req (elig),
    .ptr (ptr_q),
    .gnt (pick)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    a_gnt_d       = 1'b0;
    b_gnt_d       = 1'b0;
    rf_en_write_d = 1'b0;
    rf_en_read_d  = 1'b0;
    rf_address_d  = rf_address_q;
    rf_data_in_d  = rf_data_in_q;
    rd_owner_d    = rd_owner_q;
    init_busy_d   = init_busy_q;
    init_done_d   = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (init_go) begin
          state_d     = ST_INIT;
          init_busy_d = 1'b1;
          cnt_d       = '0;
        end else if (pick != 2'b00) begin
          a_gnt_d       = pick[0];
          b_gnt_d       = pick[1];
          ptr_d         = pick[0] ? PTR_B : PTR_A;
          rf_en_write_d = sel_we;
          rf_en_read_d  = !sel_we;
          rf_address_d  = pick[0] ? a_addr : b_addr;
          rf_data_in_d  = pick[0] ? a_wdata : b_wdata;
          rd_owner_d    = pick[1];
        end
      end
      ST_INIT: begin
        // The extra counter bit marks the cycle after the last write was issued.
        if (!cnt_q[ADDR_DEPTH]) begin
          rf_en_write_d = 1'b1;
          rf_address_d  = cnt_q[ADDR_DEPTH-1:0];
          rf_data_in_d  = '0;
          cnt_d         = cnt_q + CNT_W'(1);
        end else begin
          state_d     = ST_ARB;
          init_busy_d = 1'b0;
          init_done_d = 1'b1;
          cnt_d       = '0;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Read return: command issued -> data on rf_data_out next cycle -> registered out.
  always_comb begin
    rd_vld_p1_d   = rf_en_read_q;
    rd_owner_p1_d = rd_owner_q;
    a_rvalid_d    = rd_vld_p1_q && !rd_owner_p1_q;
    b_rvalid_d    = rd_vld_p1_q && rd_owner_p1_q;
    a_rdata_d     = (rd_vld_p1_q && !rd_owner_p1_q) ? rf_data_out : a_rdata_q;
    b_rdata_d     = (rd_vld_p1_q && rd_owner_p1_q) ? rf_data_out : b_rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_ARB;
      ptr_q         <= PTR_A;
      cnt_q         <= '0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      rf_address_q  <= '0;
      rf_en_write_q <= 1'b0;
      rf_en_read_q  <= 1'b0;
      rf_data_in_q  <= '0;
      rd_owner_q    <= 1'b0;
      rd_vld_p1_q   <= 1'b0;
      rd_owner_p1_q <= 1'b0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      init_busy_q   <= 1'b0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      a_gnt_q       <= a_gnt_d;
      b_gnt_q       <= b_gnt_d;
      rf_address_q  <= rf_address_d;
      rf_en_write_q <= rf_en_write_d;
      rf_en_read_q  <= rf_en_read_d;
      rf_data_in_q  <= rf_data_in_d;
      rd_owner_q    <= rd_owner_d;
      rd_vld_p1_q   <= rd_vld_p1_d;
      rd_owner_p1_q <= rd_owner_p1_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      init_busy_q   <= init_busy_d;
      init_done_q   <= init_done_d;
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign rf_address  = rf_address_q;
  assign rf_en_write = rf_en_write_q;
  assign rf_en_read  = rf_en_read_q;
  assign rf_data_in  = rf_data_in_q;
  assign init_busy   = init_busy_q;
  assign init_done   = init_done_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural 1-cycle-latency register file.
module tb_regfile_arbiter;

  localparam int DW = 24;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_start = 1'b0;
  logic          init_busy, init_done;
  logic          a_req = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic          a_gnt, a_rvalid;
  logic [DW-1:0] a_rdata;
  logic          b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_wdata = '0;
  logic          b_gnt, b_rvalid;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] rf_address;
  logic          rf_en_write, rf_en_read;
  logic [DW-1:0] rf_data_in;
  wire  [DW-1:0] rf_data_out;

  int checks = 0;
  int failures = 0;
  int wr, bad, ovl, gnts, done, found;

  regfile_arbiter #(.DATA_WIDTH(DW), .ADDR_DEPTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .init_start  (init_start),
    .init_busy   (init_busy),
    .init_done   (init_done),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .rf_address  (rf_address),
    .rf_en_write (rf_en_write),
    .rf_en_read  (rf_en_read),
    .rf_data_in  (rf_data_in),
    .rf_data_out (rf_data_out)
  );

  always #5 clock = ~clock;

  // Register file: data appears the cycle after the read strobe, high-Z otherwise.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          rd_pend = 1'b0;
  logic [DW-1:0] rd_word;
  always @(posedge clock) begin
    if (rf_en_write) mem[rf_address] <= rf_data_in;
    if (rf_en_read) rd_word <= mem[rf_address];
    rd_pend <= rf_en_read;
  end
  assign rf_data_out = rd_pend ? rd_word : 'z;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string t);
    chk({t, ".a_gnt"},       32'(a_gnt), 0);
    chk({t, ".b_gnt"},       32'(b_gnt), 0);
    chk({t, ".a_rvalid"},    32'(a_rvalid), 0);
    chk({t, ".b_rvalid"},    32'(b_rvalid), 0);
    chk({t, ".a_rdata"},     32'(a_rdata), 0);
    chk({t, ".b_rdata"},     32'(b_rdata), 0);
    chk({t, ".rf_address"},  32'(rf_address), 0);
    chk({t, ".rf_en_write"}, 32'(rf_en_write), 0);
    chk({t, ".rf_en_read"},  32'(rf_en_read), 0);
    chk({t, ".rf_data_in"},  32'(rf_data_in), 0);
    chk({t, ".init_busy"},   32'(init_busy), 0);
    chk({t, ".init_done"},   32'(init_done), 0);
  endtask

  // Only a is requesting, so it is granted on the very next cycle.
  task automatic do_write_a(input logic [AW-1:0] addr, input logic [DW-1:0] d, input string t);
    a_req = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = d;
    tick();
    chk({t, ".a_gnt"}, 32'(a_gnt), 1);
    chk({t, ".data"},  32'(rf_data_in), 32'(d));
    a_req = 1'b0; a_we = 1'b0;
    tick();
  endtask

  // Inspects the current cycle first, then advances until init_done or budget expiry.
  task automatic watch_init(output int w, output int b, output int o, output int g, output int dn);
    int exp_addr;
    exp_addr = 0; w = 0; b = 0; o = 0; g = 0; dn = 0;
    for (int i = 0; i < 5000; i++) begin
      if (rf_en_write) begin
        if (rf_address !== 12'(exp_addr) || rf_data_in !== '0) b++;
        exp_addr++;
        w++;
      end
      if (rf_en_write && rf_en_read) o++;
      if (a_gnt || b_gnt) g++;
      if (init_done) begin
        dn = 1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;

    // Single write by a, then read by b of the same address
    a_req = 1'b1; a_we = 1'b1; a_addr = 12'd5; a_wdata = 24'hABCDEF;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd5;
    tick();
    chk("s1.a_gnt",  32'(a_gnt), 1);
    chk("s1.b_gnt0", 32'(b_gnt), 0);
    chk("s1.wr_en",  32'(rf_en_write), 1);
    chk("s1.addr",   32'(rf_address), 5);
    chk("s1.wdata",  32'(rf_data_in), 32'h00ABCDEF);
    a_req = 1'b0; a_we = 1'b0;
    tick();
    chk("s1.b_gnt",  32'(b_gnt), 1);
    chk("s1.rd_en",  32'(rf_en_read), 1);
    chk("s1.wr_en0", 32'(rf_en_write), 0);
    b_req = 1'b0;
    tick();
    chk("s1.b_rvalid_early", 32'(b_rvalid), 0);
    tick();
    chk("s1.b_rvalid", 32'(b_rvalid), 1);
    chk("s1.b_rdata",  32'(b_rdata), 32'h00ABCDEF);
    chk("s1.a_rvalid", 32'(a_rvalid), 0);
    tick();
    chk("s1.b_rvalid_pulse", 32'(b_rvalid), 0);

    // Contention from reset: grants alternate a,b,a,b
    reset = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd1;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd5;
    tick();
    reset = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk($sformatf("s2.a_gnt_c%0d", c), 32'(a_gnt), 32'(c % 2));
      chk($sformatf("s2.b_gnt_c%0d", c), 32'(b_gnt), 32'(1 - (c % 2)));
      if (c == 3) chk("s2.a_rvalid", 32'(a_rvalid), 1);
      if (c == 4) begin
        chk("s2.b_rvalid", 32'(b_rvalid), 1);
        chk("s2.b_rdata",  32'(b_rdata), 32'h00ABCDEF);
        a_req = 1'b0; b_req = 1'b0;
      end
    end
    repeat (3) tick();

    // Init while b has a read pending; init wins and b waits
    do_write_a(12'd7, 24'h123456, "s3.wr7");
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd7;
    init_start = 1'b1;
    tick();
    chk("s3.busy_rise", 32'(init_busy), 1);
    chk("s3.b_gnt_held", 32'(b_gnt), 0);
    chk("s3.no_wr_yet", 32'(rf_en_write), 0);
    init_start = 1'b0;
    watch_init(wr, bad, ovl, gnts, done);
    chk("s3.done_seen", 32'(done), 1);
    chk("s3.writes", 32'(wr), 4096);
    chk("s3.bad_writes", 32'(bad), 0);
    chk("s3.overlap", 32'(ovl), 0);
    chk("s3.grants_in_init", 32'(gnts), 0);
    chk("s3.busy_fall", 32'(init_busy), 0);
    tick();
    chk("s3.done_pulse", 32'(init_done), 0);
    chk("s3.b_gnt", 32'(b_gnt), 1);
    chk("s3.b_addr", 32'(rf_address), 7);
    b_req = 1'b0;
    tick();
    tick();
    chk("s3.b_rvalid", 32'(b_rvalid), 1);
    chk("s3.b_rdata_zero", 32'(b_rdata), 0);

    // Read granted in the same cycle as init_start
    do_write_a(12'd9, 24'h5A5A5A, "s4.wr9");
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd9;
    tick();
    chk("s4.a_gnt", 32'(a_gnt), 1);
    chk("s4.rd_en", 32'(rf_en_read), 1);
    a_req = 1'b0;
    init_start = 1'b1;
    tick();
    chk("s4.busy", 32'(init_busy), 1);
    chk("s4.idle_rd", 32'(rf_en_read), 0);
    chk("s4.idle_wr", 32'(rf_en_write), 0);
    init_start = 1'b0;
    tick();
    chk("s4.a_rvalid", 32'(a_rvalid), 1);
    chk("s4.a_rdata", 32'(a_rdata), 32'h005A5A5A);
    chk("s4.first_wr", 32'(rf_en_write), 1);
    chk("s4.first_addr", 32'(rf_address), 0);
    watch_init(wr, bad, ovl, gnts, done);
    chk("s4.done_seen", 32'(done), 1);
    chk("s4.writes", 32'(wr), 4096);
    chk("s4.overlap", 32'(ovl), 0);
    tick();

    // Reset in the middle of init, then a must win first contention
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      if (rf_en_write && rf_address == 12'd100) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("s5.reached100", 32'(found), 1);
    reset = 1'b1;
    tick();
    check_zero("s5.reset");
    reset = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 12'd3;
    b_req = 1'b1; b_we = 1'b0; b_addr = 12'd4;
    tick();
    chk("s5.a_first", 32'(a_gnt), 1);
    chk("s5.b_not_first", 32'(b_gnt), 0);
    chk("s5.no_init_wr", 32'(rf_en_write), 0);
    chk("s5.busy_low", 32'(init_busy), 0);
    tick();
    chk("s5.b_second", 32'(b_gnt), 1);
    chk("s5.no_init_wr2", 32'(rf_en_write), 0);
    a_req = 1'b0; b_req = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
